mmu_utlb: RTL and testbench

//  Sequential address-translation unit with a private fully-associative micro-TLB (uTLB) in

---
 rtl/mmu_utlb.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_mmu_utlb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_utlb.sv
// Address-translation unit: direct / DMW / paged translation through a private micro-TLB,
// walking the shared main-TLB search port on a miss. Optional MMU_UTLB_PERF_EN adds hit/miss counters.
module mmu_utlb #(
    parameter int ENTRIES  = 4,
    parameter int ASID_W   = 10,
    parameter int IS_FETCH = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_vaddr,
    input  logic              req_we,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_paddr,
    output logic [1:0]        resp_mat,
    output logic [2:0]        resp_exc,
    input  logic [31:0]       csr_crmd,
    input  logic [31:0]       csr_asid,
    input  logic [31:0]       csr_dmw0,
    input  logic [31:0]       csr_dmw1,
    input  logic              utlb_flush,
    output logic [18:0]       s_vppn,
    output logic              s_va_bit12,
    output logic [ASID_W-1:0] s_asid,
    input  logic              s_found,
    input  logic [19:0]       s_ppn,
    input  logic [5:0]        s_ps,
    input  logic [1:0]        s_plv,
    input  logic [1:0]        s_mat,
    input  logic              s_d,
    input  logic              s_v,
    input  logic              s_g
`ifdef MMU_UTLB_PERF_EN
    ,
    output logic [31:0]       perf_hit,
    output logic [31:0]       perf_miss
`endif
);
    // Handshakes: a request transfers on a cycle where req_valid & req_ready; a response
    // transfers on a cycle where resp_valid & resp_ready, and resp_* hold steady until then.
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_TLBR = 3'd1;
    localparam logic [2:0] EXC_PIF  = 3'd2;
    localparam logic [2:0] EXC_PIL  = 3'd3;
    localparam logic [2:0] EXC_PIS  = 3'd4;
    localparam logic [2:0] EXC_PPI  = 3'd5;
    localparam logic [2:0] EXC_PME  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_LOOK, S_WALK, S_RESP} state_t;
    state_t state, state_nx;

    // Request context captured at acceptance
    logic [31:0]       lat_vaddr;
    logic              lat_we;
    logic [1:0]        lat_plv;
    logic              lat_da, lat_pg;
    logic [1:0]        lat_datf;
    logic [2:0]        lat_d0_vseg, lat_d0_pseg, lat_d1_vseg, lat_d1_pseg;
    logic [1:0]        lat_d0_mat, lat_d1_mat;
    logic [3:0]        lat_d0_plv, lat_d1_plv;
    logic [ASID_W-1:0] lat_asid;

    logic [31:0] res_paddr;
    logic [1:0]  res_mat;
    logic [2:0]  res_exc;

    logic [ENTRIES-1:0] ent_valid;
    logic [19:0]        ent_tag  [ENTRIES];
    logic               ent_2m   [ENTRIES];
    logic [ASID_W-1:0]  ent_asid [ENTRIES];
    logic               ent_g    [ENTRIES];
    logic [19:0]        ent_ppn  [ENTRIES];
    logic [1:0]         ent_plv  [ENTRIES];
    logic [1:0]         ent_mat  [ENTRIES];
    logic               ent_d    [ENTRIES];
    logic [IDX_W-1:0]   rr_ptr;

    logic unused_csr;
    assign unused_csr = ^{csr_crmd[31:7], csr_crmd[2], csr_asid,
                          csr_dmw0[28], csr_dmw0[24:6], csr_dmw1[28], csr_dmw1[24:6]};

    logic direct, dmw0_hit, dmw1_hit;
    assign direct   = lat_da & ~lat_pg;
    assign dmw0_hit = (lat_vaddr[31:29] == lat_d0_vseg) & lat_d0_plv[lat_plv];
    assign dmw1_hit = (lat_vaddr[31:29] == lat_d1_vseg) & lat_d1_plv[lat_plv];

    logic [ENTRIES-1:0] ent_match;
    logic               utlb_hit, has_inv;
    logic [IDX_W-1:0]   hit_idx, inv_idx, victim;

    always_comb begin
        ent_match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ent_match[i] = ent_valid[i]
                & (ent_2m[i] ? (ent_tag[i][19:9] == lat_vaddr[31:21]) : (ent_tag[i] == lat_vaddr[31:12]))
                & (ent_g[i] | (ent_asid[i] == lat_asid));
        end
    end

    // Downward scans so the lowest index wins both the hit and the free-slot search
    always_comb begin
        utlb_hit = 1'b0;
        hit_idx  = '0;
        has_inv  = 1'b0;
        inv_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_match[i]) begin
                utlb_hit = 1'b1;
                hit_idx  = IDX_W'(i);
            end
            if (!ent_valid[i]) begin
                has_inv = 1'b1;
                inv_idx = IDX_W'(i);
            end
        end
        victim = has_inv ? inv_idx : rr_ptr;
    end

    logic        look_done;
    logic [31:0] look_paddr;
    logic [1:0]  look_mat;
    logic [2:0]  look_exc;

    always_comb begin
        look_done  = 1'b1;
        look_paddr = lat_vaddr;
        look_mat   = 2'd0;
        look_exc   = EXC_NONE;
        if (direct) begin
            look_mat = lat_datf;
        end else if (dmw0_hit) begin
            look_paddr = {lat_d0_pseg, lat_vaddr[28:0]};
            look_mat   = lat_d0_mat;
        end else if (dmw1_hit) begin
            look_paddr = {lat_d1_pseg, lat_vaddr[28:0]};
            look_mat   = lat_d1_mat;
        end else if (utlb_hit) begin
            look_paddr = ent_2m[hit_idx] ? {ent_ppn[hit_idx][19:9], lat_vaddr[20:0]}
                                         : {ent_ppn[hit_idx], lat_vaddr[11:0]};
            look_mat   = ent_mat[hit_idx];
            if (lat_plv > ent_plv[hit_idx])
                look_exc = EXC_PPI;
            else if (lat_we && !ent_d[hit_idx])
                look_exc = EXC_PME;
        end else begin
            look_done = 1'b0;
        end
    end

    logic        ps_ok, walk_2m, fill_en;
    logic [31:0] walk_paddr;
    logic [2:0]  walk_exc;

    assign ps_ok   = (s_ps == 6'd12) || (s_ps == 6'd21);
    assign walk_2m = (s_ps == 6'd21);
    assign fill_en = (state == S_WALK) & s_found & s_v & ps_ok & ~utlb_flush;

    always_comb begin
        walk_paddr = walk_2m ? {s_ppn[19:9], lat_vaddr[20:0]} : {s_ppn, lat_vaddr[11:0]};
        walk_exc   = EXC_NONE;
        if (!s_found || !ps_ok)
            walk_exc = EXC_TLBR;
        else if (!s_v)
            walk_exc = (IS_FETCH != 0) ? EXC_PIF : (lat_we ? EXC_PIS : EXC_PIL);
        else if (lat_plv > s_plv)
            walk_exc = EXC_PPI;
        else if (lat_we && !s_d)
            walk_exc = EXC_PME;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = (state == S_IDLE);
        resp_valid = 1'b0;
        unique case (state)
            S_IDLE: if (req_valid) state_nx = S_LOOK;
            S_LOOK: begin
                if (look_done) begin
                    resp_valid = 1'b1;
                    state_nx   = resp_ready ? S_IDLE : S_RESP;
                end else begin
                    state_nx = S_WALK;
                end
            end
            S_WALK: state_nx = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign resp_paddr = (state == S_LOOK && look_done) ? look_paddr : res_paddr;
    assign resp_mat   = (state == S_LOOK && look_done) ? look_mat   : res_mat;
    assign resp_exc   = (state == S_LOOK && look_done) ? look_exc   : res_exc;

    assign s_vppn     = lat_vaddr[31:13];
    assign s_va_bit12 = lat_vaddr[12];
    assign s_asid     = lat_asid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            lat_vaddr   <= '0;
            lat_we      <= 1'b0;
            lat_plv     <= '0;
            lat_da      <= 1'b0;
            lat_pg      <= 1'b0;
            lat_datf    <= '0;
            lat_d0_vseg <= '0;
            lat_d0_pseg <= '0;
            lat_d0_mat  <= '0;
            lat_d0_plv  <= '0;
            lat_d1_vseg <= '0;
            lat_d1_pseg <= '0;
            lat_d1_mat  <= '0;
            lat_d1_plv  <= '0;
            lat_asid    <= '0;
            res_paddr   <= '0;
            res_mat     <= '0;
            res_exc     <= EXC_NONE;
            ent_valid   <= '0;
            rr_ptr      <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req_valid) begin
                lat_vaddr   <= req_vaddr;
                lat_we      <= req_we;
                lat_plv     <= csr_crmd[1:0];
                lat_da      <= csr_crmd[3];
                lat_pg      <= csr_crmd[4];
                lat_datf    <= csr_crmd[6:5];
                lat_d0_vseg <= csr_dmw0[31:29];
                lat_d0_pseg <= csr_dmw0[27:25];
                lat_d0_mat  <= csr_dmw0[5:4];
                lat_d0_plv  <= csr_dmw0[3:0];
                lat_d1_vseg <= csr_dmw1[31:29];
                lat_d1_pseg <= csr_dmw1[27:25];
                lat_d1_mat  <= csr_dmw1[5:4];
                lat_d1_plv  <= csr_dmw1[3:0];
                lat_asid    <= csr_asid[ASID_W-1:0];
            end
            if (state == S_LOOK && look_done) begin
                res_paddr <= look_paddr;
                res_mat   <= look_mat;
                res_exc   <= look_exc;
            end
            if (state == S_WALK) begin
                res_paddr <= walk_paddr;
                res_mat   <= s_mat;
                res_exc   <= walk_exc;
            end
            // A flush on the fill edge wins; the response above is still taken from the search
            if (utlb_flush)
                ent_valid <= '0;
            else if (fill_en)
                ent_valid[victim] <= 1'b1;
            if (fill_en)
                rr_ptr <= rr_ptr + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            ent_tag[victim]  <= lat_vaddr[31:12];
            ent_2m[victim]   <= walk_2m;
            ent_asid[victim] <= lat_asid;
            ent_g[victim]    <= s_g;
            ent_ppn[victim]  <= s_ppn;
            ent_plv[victim]  <= s_plv;
            ent_mat[victim]  <= s_mat;
            ent_d[victim]    <= s_d;
        end
    end

`ifdef MMU_UTLB_PERF_EN
    logic paged_look;
    assign paged_look = (state == S_LOOK) & ~direct & ~dmw0_hit & ~dmw1_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hit  <= '0;
            perf_miss <= '0;
        end else begin
            if (paged_look && utlb_hit && perf_hit != 32'hFFFF_FFFF)
                perf_hit <= perf_hit + 32'd1;
            if (paged_look && !utlb_hit && perf_miss != 32'hFFFF_FFFF)
                perf_miss <= perf_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mmu_utlb.sv
// Bench for mmu_utlb: a data-side and a fetch-side instance share all stimulus; expected
// responses are queued when a request is driven and compared when resp_valid appears.
module tb_mmu_utlb;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, resp_ready, utlb_flush;
    logic [31:0] req_vaddr, csr_crmd, csr_asid, csr_dmw0, csr_dmw1;
    logic        s_found, s_d, s_v, s_g;
    logic [19:0] s_ppn;
    logic [5:0]  s_ps;
    logic [1:0]  s_plv, s_mat;

    logic        req_ready, resp_valid;
    logic [31:0] resp_paddr;
    logic [1:0]  resp_mat;
    logic [2:0]  resp_exc;
    logic [18:0] s_vppn;
    logic        s_va_bit12;
    logic [9:0]  s_asid;

    logic        f_req_ready, f_resp_valid;
    logic [31:0] f_resp_paddr;
    logic [1:0]  f_resp_mat;
    logic [2:0]  f_resp_exc;
    logic [18:0] f_s_vppn;
    logic        f_s_va_bit12;
    logic [9:0]  f_s_asid;
`ifdef MMU_UTLB_PERF_EN
    logic [31:0] perf_hit, perf_miss, f_perf_hit, f_perf_miss;
`endif

    always #5 clk = ~clk;

    mmu_utlb #(.ENTRIES(4), .ASID_W(10), .IS_FETCH(0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_vaddr(req_vaddr), .req_we(req_we), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_paddr(resp_paddr), .resp_mat(resp_mat), .resp_exc(resp_exc),
        .csr_crmd(csr_crmd), .csr_asid(csr_asid), .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
        .utlb_flush(utlb_flush), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
        .s_found(s_found), .s_ppn(s_ppn), .s_ps(s_ps), .s_plv(s_plv), .s_mat(s_mat),
        .s_d(s_d), .s_v(s_v), .s_g(s_g)
`ifdef MMU_UTLB_PERF_EN
        , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
    );

    mmu_utlb #(.ENTRIES(4), .ASID_W(10), .IS_FETCH(1)) dut_fetch (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(f_req_ready),
        .req_vaddr(req_vaddr), .req_we(req_we), .resp_valid(f_resp_valid), .resp_ready(resp_ready),
        .resp_paddr(f_resp_paddr), .resp_mat(f_resp_mat), .resp_exc(f_resp_exc),
        .csr_crmd(csr_crmd), .csr_asid(csr_asid), .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
        .utlb_flush(utlb_flush), .s_vppn(f_s_vppn), .s_va_bit12(f_s_va_bit12), .s_asid(f_s_asid),
        .s_found(s_found), .s_ppn(s_ppn), .s_ps(s_ps), .s_plv(s_plv), .s_mat(s_mat),
        .s_d(s_d), .s_v(s_v), .s_g(s_g)
`ifdef MMU_UTLB_PERF_EN
        , .perf_hit(f_perf_hit), .perf_miss(f_perf_miss)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    // {latency[7:0], exc[2:0], mat[1:0], paddr[31:0]}
    logic [44:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_tlb(input logic found, input logic v, input logic [5:0] ps,
                           input logic [19:0] ppn, input logic [1:0] plv, input logic [1:0] mat,
                           input logic d, input logic g);
        s_found = found; s_v = v; s_ps = ps; s_ppn = ppn;
        s_plv = plv; s_mat = mat; s_d = d; s_g = g;
    endtask

    task automatic tlb_none();
        set_tlb(1'b0, 1'b0, 6'd12, 20'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // flush_cyc: cycle after acceptance whose closing edge sees utlb_flush (0 = none)
    task automatic do_req(input logic [31:0] va, input logic we, input logic [31:0] ep,
                          input logic [1:0] em, input logic [2:0] ee, input int el,
                          input int flush_cyc, input int hold);
        logic [44:0] e;
        logic [2:0]  fexc;
        int          lat;
        bit          got;
        exp_q.push_back({8'(el), ee, em, ep});
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_vaddr  = va;
        req_we     = we;
        resp_ready = (hold == 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            utlb_flush = (lat == flush_cyc);
            if (lat == 2 && el == 3) begin
                check("walk_s_vppn", s_vppn, va[31:13]);
                check("walk_s_bit12", s_va_bit12, va[12]);
                check("walk_s_asid", s_asid, csr_asid[9:0]);
            end
            if (resp_valid) got = 1'b1;
        end
        e = exp_q.pop_front();
        if (!got) begin
            check("resp_timeout", 1'b0, 1'b1);
        end else begin
            check("latency", 64'(lat), 64'(e[44:37]));
            check("exc", resp_exc, e[36:34]);
            if (e[36:34] == 3'd0) begin
                check("mat", resp_mat, e[33:32]);
                check("paddr", resp_paddr, e[31:0]);
            end
            fexc = (e[36:34] == 3'd3 || e[36:34] == 3'd4) ? 3'd2 : e[36:34];
            check("fetch_valid", f_resp_valid, 1'b1);
            check("fetch_exc", f_resp_exc, fexc);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                utlb_flush = 1'b0;
                check("hold_valid", resp_valid, 1'b1);
                check("hold_req_ready", req_ready, 1'b0);
                check("hold_paddr", resp_paddr, e[31:0]);
                check("hold_exc", resp_exc, e[36:34]);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1 utlb_flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va;
        logic [19:0] ppn;
        logic [1:0]  datf;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_vaddr = '0; resp_ready = 1'b1;
        utlb_flush = 1'b0; csr_crmd = '0; csr_asid = 32'd5; csr_dmw0 = '0; csr_dmw1 = '0;
        tlb_none();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_paddr", resp_paddr, 32'h0);
        check("rst_mat", resp_mat, 2'd0);
        check("rst_exc", resp_exc, 3'd0);
        reset = 1'b0;

        // Direct translation
        csr_crmd = 32'h0000_0028;
        do_req(32'h1C00_0100, 1'b0, 32'h1C00_0100, 2'd1, 3'd0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            datf = 2'($urandom_range(0, 3));
            csr_crmd = 32'h8 | (32'(datf) << 5);
            va = $urandom;
            do_req(va, 1'($urandom_range(0, 1)), va, datf, 3'd0, 1, 0, 0);
        end

        // Direct-map windows
        csr_crmd = 32'h10;
        csr_dmw0 = 32'h9000_0011;
        csr_dmw1 = 32'hA200_0021;
        do_req(32'h9000_2000, 1'b0, 32'h1000_2000, 2'd1, 3'd0, 1, 0, 0);
        do_req(32'hA000_0040, 1'b1, 32'h2000_0040, 2'd2, 3'd0, 1, 0, 0);
        csr_dmw1 = 32'h9200_0021;
        do_req(32'h9000_2000, 1'b0, 32'h1000_2000, 2'd1, 3'd0, 1, 0, 0);
        csr_dmw1 = 32'hA200_0021;

        // Miss then hit, ASID and global matching
        set_tlb(1'b1, 1'b1, 6'd12, 20'h12345, 2'd0, 2'd1, 1'b1, 1'b0);
        do_req(32'h0040_3ABC, 1'b0, 32'h1234_5ABC, 2'd1, 3'd0, 3, 0, 0);
        tlb_none();
        do_req(32'h0040_3ABC, 1'b0, 32'h1234_5ABC, 2'd1, 3'd0, 1, 0, 0);
        do_req(32'h0040_3004, 1'b0, 32'h1234_5004, 2'd1, 3'd0, 1, 0, 0);
        csr_asid = 32'd6;
        set_tlb(1'b1, 1'b1, 6'd12, 20'h22222, 2'd0, 2'd1, 1'b1, 1'b0);
        do_req(32'h0040_3ABC, 1'b0, 32'h2222_2ABC, 2'd1, 3'd0, 3, 0, 0);
        csr_asid = 32'd5;
        tlb_none();
        do_req(32'h0040_3ABC, 1'b0, 32'h1234_5ABC, 2'd1, 3'd0, 1, 0, 0);
        set_tlb(1'b1, 1'b1, 6'd12, 20'h33333, 2'd0, 2'd2, 1'b1, 1'b1);
        do_req(32'h0050_0000, 1'b0, 32'h3333_3000, 2'd2, 3'd0, 3, 0, 0);
        csr_asid = 32'd7;
        tlb_none();
        do_req(32'h0050_0008, 1'b0, 32'h3333_3008, 2'd2, 3'd0, 1, 0, 0);
        csr_asid = 32'd5;

        // Exceptions and their priority, rechecked on uTLB hits
        set_tlb(1'b1, 1'b1, 6'd12, 20'h44444, 2'd0, 2'd0, 1'b0, 1'b0);
        do_req(32'h0060_0010, 1'b1, 32'h0, 2'd0, 3'd6, 3, 0, 0);
        tlb_none();
        do_req(32'h0060_0010, 1'b0, 32'h4444_4010, 2'd0, 3'd0, 1, 0, 0);
        do_req(32'h0060_0020, 1'b1, 32'h0, 2'd0, 3'd6, 1, 0, 0);
        do_req(32'h0070_0000, 1'b0, 32'h0, 2'd0, 3'd1, 3, 0, 0);
        set_tlb(1'b1, 1'b0, 6'd12, 20'h44444, 2'd0, 2'd0, 1'b1, 1'b0);
        do_req(32'h0071_0000, 1'b0, 32'h0, 2'd0, 3'd3, 3, 0, 0);
        do_req(32'h0071_0000, 1'b1, 32'h0, 2'd0, 3'd4, 3, 0, 0);
        csr_crmd = 32'h13;
        do_req(32'h0072_0000, 1'b0, 32'h0, 2'd0, 3'd3, 3, 0, 0);
        set_tlb(1'b1, 1'b1, 6'd12, 20'h55555, 2'd0, 2'd0, 1'b0, 1'b0);
        do_req(32'h0080_0000, 1'b1, 32'h0, 2'd0, 3'd5, 3, 0, 0);
        csr_crmd = 32'h10;
        tlb_none();
        do_req(32'h0080_0004, 1'b1, 32'h0, 2'd0, 3'd6, 1, 0, 0);
        set_tlb(1'b1, 1'b1, 6'd14, 20'h55555, 2'd0, 2'd0, 1'b1, 1'b0);
        do_req(32'h0090_0000, 1'b0, 32'h0, 2'd0, 3'd1, 3, 0, 0);

        // 2 MiB page
        set_tlb(1'b1, 1'b1, 6'd21, 20'hABCDE, 2'd0, 2'd1, 1'b1, 1'b0);
        do_req(32'h0123_4567, 1'b0, 32'hABC3_4567, 2'd1, 3'd0, 3, 0, 0);
        tlb_none();
        do_req(32'h0120_0010, 1'b0, 32'hABC0_0010, 2'd1, 3'd0, 1, 0, 0);

        // Replacement: four free slots, then the round-robin pointer picks entry 0
        do_reset();
        csr_crmd = 32'h10;
        csr_asid = 32'd5;
        for (int i = 0; i < 5; i++) begin
            set_tlb(1'b1, 1'b1, 6'd12, 20'h60000 + 20'(i), 2'd0, 2'd1, 1'b1, 1'b0);
            do_req(32'h0100_0000 + (32'(i) << 12), 1'b0, (32'h6000_0000 + (32'(i) << 12)),
                   2'd1, 3'd0, 3, 0, 0);
        end
        tlb_none();
        do_req(32'h0100_1040, 1'b0, 32'h6000_1040, 2'd1, 3'd0, 1, 0, 0);
        do_req(32'h0100_0040, 1'b0, 32'h0, 2'd0, 3'd1, 3, 0, 0);

        // Flush on the fill edge and during LOOK
        set_tlb(1'b1, 1'b1, 6'd12, 20'h70000, 2'd0, 2'd1, 1'b1, 1'b0);
        do_req(32'h0200_0000, 1'b0, 32'h7000_0000, 2'd1, 3'd0, 3, 2, 0);
        tlb_none();
        do_req(32'h0200_0000, 1'b0, 32'h0, 2'd0, 3'd1, 3, 0, 0);
        set_tlb(1'b1, 1'b1, 6'd12, 20'h71000, 2'd0, 2'd1, 1'b1, 1'b0);
        do_req(32'h0210_0000, 1'b0, 32'h7100_0000, 2'd1, 3'd0, 3, 0, 0);
        tlb_none();
        do_req(32'h0210_0000, 1'b0, 32'h7100_0000, 2'd1, 3'd0, 1, 1, 0);
        do_req(32'h0210_0000, 1'b0, 32'h0, 2'd0, 3'd1, 3, 0, 0);

        // Backpressure on a LOOK response and on a RESP response
        do_req(32'h9000_2000, 1'b0, 32'h1000_2000, 2'd1, 3'd0, 1, 0, 3);
        set_tlb(1'b1, 1'b1, 6'd12, 20'h72000, 2'd0, 2'd3, 1'b1, 1'b0);
        do_req(32'h0220_0000, 1'b0, 32'h7200_0000, 2'd3, 3'd0, 3, 0, 3);

        // Reset while walking
        set_tlb(1'b1, 1'b1, 6'd12, 20'h73000, 2'd0, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_vaddr = 32'h0230_0000;
        req_we    = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstwalk_look_valid", resp_valid, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstwalk_valid", resp_valid, 1'b0);
        check("rstwalk_req_ready", req_ready, 1'b1);
        check("rstwalk_paddr", resp_paddr, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rstwalk_discard", resp_valid, 1'b0);
        tlb_none();
        do_req(32'h0220_0000, 1'b0, 32'h0, 2'd0, 3'd1, 3, 0, 0);

        // Random 4 KiB pages: miss fills, a second offset in the page hits
        for (int i = 0; i < 4; i++) begin
            ppn = 20'($urandom_range(0, 20'hFFFFF));
            va  = 32'h0300_0000 + (32'(i) << 12) + 32'($urandom_range(0, 4095));
            set_tlb(1'b1, 1'b1, 6'd12, ppn, 2'd0, 2'd1, 1'b1, 1'b0);
            do_req(va, 1'b0, {ppn, va[11:0]}, 2'd1, 3'd0, 3, 0, 0);
            tlb_none();
            va[11:0] = 12'($urandom_range(0, 4095));
            do_req(va, 1'b0, {ppn, va[11:0]}, 2'd1, 3'd0, 1, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
